uart_rx_byte: RTL and testbench

- Serial UART receiver for the 7-segment UART-control path.
- Sits directly upstream of the nibble splitter and produces its 8-bit data input.
- Receives 8N1 frames, LSB first, and presents each good byte on a held output register with a one-cycle valid strobe.
- Bad frames are flagged and the held byte is left untouched, so the downstream change-detect only sees genuine new bytes.

---
 rtl/uart_rx_byte.sv | 142 ++++++++++++++
 tb/tb_uart_rx_byte.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_byte
// Description : 8N1 UART receiver with a single mid-bit sample; good bytes
//               update a held data register with a one-cycle valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             rx_meta_q, rx_s_q;

    // Both stages reset high so a reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                // A high line at mid-start is treated as a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                // Leaving mid-stop-bit lets the next start bit follow directly.
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_byte
// Description : Scoreboard bench for uart_rx_byte with a bit-accurate serial
//               driver; expected pulses carry byte, kind and exact cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_byte;

    localparam int CPB = 8;
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    typedef struct {
        bit         err;
        logic [7:0] d;
        int         cyc;
    } exp_t;

    exp_t       sbq[$];
    int         total;
    int         bad;
    int         cyc;
    int         n_valid;
    int         n_err;
    logic [7:0] held;

    uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Caller is always #1 after a posedge; the start bit begins in that cycle.
    task automatic send(input logic [7:0] b, input bit stop_ok);
        logic [9:0] fr;
        exp_t       e;
        fr    = {stop_ok, b, 1'b0};
        e.err = !stop_ok;
        e.cyc = cyc + LAT;
        if (stop_ok) held = b;
        e.d   = held;
        sbq.push_back(e);
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (CPB) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (valid && frame_err) begin
                total++;
                bad++;
                $display("FAIL both_pulses: valid=%0b frame_err=%0b at cycle %0d", valid, frame_err, cyc);
            end
            if (valid || frame_err) begin
                exp_t e;
                if (valid) n_valid++;
                if (frame_err) n_err++;
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b data=0x%0h at cycle %0d",
                             valid, frame_err, data, cyc);
                end else begin
                    e = sbq.pop_front();
                    if (frame_err != e.err || data != e.d || cyc != e.cyc) begin
                        bad++;
                        $display("FAIL pulse: got err=%0b data=0x%0h cycle=%0d expected err=%0b data=0x%0h cycle=%0d",
                                 frame_err, data, cyc, e.err, e.d, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int gap;
        total   = 0;
        bad     = 0;
        n_valid = 0;
        n_err   = 0;
        held    = 8'h00;
        reset   = 1'b1;
        rx      = 1'b1;

        // 1. reset state and quiet idle line
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_data", data, 8'h00);
        chk("rst_valid", valid, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_busy", busy, 0);
        idle(50);
        chk("idle_data", data, 8'h00);
        chk("idle_busy", busy, 0);

        // 2. single frame, held afterwards
        send(8'hA5, 1'b1);
        idle(200);
        chk("a5_held", data, 8'hA5);
        chk("a5_count", n_valid, 1);

        // 3. back-to-back frames, busy may drop only briefly between them
        send(8'h3C, 1'b1);
        send(8'hC3, 1'b1);
        idle(20);
        chk("b2b_data", data, 8'hC3);
        chk("b2b_count", n_valid, 3);

        // 4. false start: two low cycles
        rx = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rx = 1'b1;
        @(posedge clk); #1;
        chk("glitch_busy_hi", busy, 1);
        idle(CPB);
        chk("glitch_busy_lo", busy, 0);
        chk("glitch_data", data, 8'hC3);

        // 5. framing error then stuck-low line
        send(8'hA5, 1'b1);
        send(8'h55, 1'b0);
        rx = 1'b0;
        repeat (30) begin @(posedge clk); #1; end
        chk("brk_busy", busy, 1);
        rx = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        chk("brk_busy_rel2", busy, 1);
        @(posedge clk); #1;
        chk("brk_busy_rel3", busy, 0);
        chk("ferr_data", data, 8'hA5);
        chk("ferr_count", n_err, 1);
        idle(16);
        send(8'h0F, 1'b1);
        idle(20);
        chk("post_err_data", data, 8'h0F);

        // 6. reset during data bit 4 of 0xFF
        rx = 1'b0;
        repeat (CPB) begin @(posedge clk); #1; end
        rx = 1'b1;
        repeat (4 * CPB + CPB / 2) begin @(posedge clk); #1; end
        chk("pre_rst_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        held  = 8'h00;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_data", data, 8'h00);
        idle(10 * CPB);
        send(8'h81, 1'b1);
        idle(20);
        chk("final_data", data, 8'h81);

        gap = sbq.size();
        chk("sb_empty", gap, 0);
        chk("valid_total", n_valid, 6);
        chk("ferr_total", n_err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
